// File: rtl/pwm_duty_meter.sv
// pwm_duty_meter
//   Monitors a PWM waveform that is asynchronous to clk. Measures the high time
//   and the rising-edge-to-rising-edge period in clk cycles, and publishes each
//   completed period with a one-cycle strobe. Flags a line with no edges
//   (0 %/100 % duty or dead output) and periods too long for the counters.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   en           measurement enable; low forces IDLE and clears results/flags
//   pwm_in       PWM waveform (asynchronous)
//   high_cnt     high time of the last published period
//   period_cnt   last published period
//   meas_valid   one-cycle pulse when high_cnt/period_cnt update
//   stuck        no edge seen for TIMEOUT cycles
//   stuck_level  synchronized pwm_in level when stuck was set
//   overflow     sticky; a period saturated the counter and was discarded
module pwm_duty_meter #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             meas_valid,
  output logic             stuck,
  output logic             stuck_level,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_ARM, ST_HIGH, ST_LOW, ST_STUCK} state_t;

  state_t           state_reg, state_next;
  logic [2:0]       sync_reg;
  logic [CNT_W-1:0] per_ctr_reg, hi_ctr_reg, hi_hold_reg, idle_ctr_reg;
  logic             rise, fall, counting, timeout_hit;
  logic             load_ctr, hold_hi, publish, ovf_set, stuck_set, stuck_clr;

  // Synchronizer runs independently of en so edge detection is valid the
  // moment measurement is re-enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_reg <= 3'b000;
    else        sync_reg <= {sync_reg[1:0], pwm_in};
  end

  assign rise = sync_reg[1] & ~sync_reg[2];
  assign fall = ~sync_reg[1] & sync_reg[2];

  assign counting    = (state_reg == ST_ARM) || (state_reg == ST_HIGH) ||
                       (state_reg == ST_LOW);
  assign timeout_hit = counting && !rise && !fall && (idle_ctr_reg == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    load_ctr   = 1'b0;
    hold_hi    = 1'b0;
    publish    = 1'b0;
    ovf_set    = 1'b0;
    stuck_set  = 1'b0;
    stuck_clr  = 1'b0;
    if (!en) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: state_next = ST_ARM;
        ST_ARM: begin
          // First rise only opens a measurement; nothing to publish yet.
          if (rise) begin
            state_next = ST_HIGH;
            load_ctr   = 1'b1;
          end else if (timeout_hit) begin
            state_next = ST_STUCK;
            stuck_set  = 1'b1;
          end
        end
        ST_HIGH: begin
          if (fall) begin
            state_next = ST_LOW;
            hold_hi    = 1'b1;
          end else if (timeout_hit) begin
            state_next = ST_STUCK;
            stuck_set  = 1'b1;
          end
        end
        ST_LOW: begin
          if (rise) begin
            state_next = ST_HIGH;
            load_ctr   = 1'b1;
            // A saturated period counter means the true length is unknown.
            if (per_ctr_reg == CNT_MAX) ovf_set = 1'b1;
            else                        publish = 1'b1;
          end else if (timeout_hit) begin
            state_next = ST_STUCK;
            stuck_set  = 1'b1;
          end
        end
        ST_STUCK: begin
          if (rise) begin
            state_next = ST_HIGH;
            load_ctr   = 1'b1;
            stuck_clr  = 1'b1;
          end else if (fall) begin
            state_next = ST_ARM;
            stuck_clr  = 1'b1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_ctr_reg  <= '0;
      hi_ctr_reg   <= '0;
      hi_hold_reg  <= '0;
      idle_ctr_reg <= '0;
      high_cnt     <= '0;
      period_cnt   <= '0;
      meas_valid   <= 1'b0;
      stuck        <= 1'b0;
      stuck_level  <= 1'b0;
      overflow     <= 1'b0;
    end else if (!en) begin
      per_ctr_reg  <= '0;
      hi_ctr_reg   <= '0;
      hi_hold_reg  <= '0;
      idle_ctr_reg <= '0;
      high_cnt     <= '0;
      period_cnt   <= '0;
      meas_valid   <= 1'b0;
      stuck        <= 1'b0;
      stuck_level  <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      meas_valid <= publish;

      if (rise || fall || !counting || stuck_set) idle_ctr_reg <= '0;
      else                                        idle_ctr_reg <= idle_ctr_reg + CNT_ONE;

      // Counters load 1 in the rise cycle so results equal edge-to-edge distance.
      if (load_ctr)
        per_ctr_reg <= CNT_ONE;
      else if ((state_reg == ST_HIGH || state_reg == ST_LOW) && per_ctr_reg != CNT_MAX)
        per_ctr_reg <= per_ctr_reg + CNT_ONE;

      if (load_ctr)
        hi_ctr_reg <= CNT_ONE;
      else if (state_reg == ST_HIGH && hi_ctr_reg != CNT_MAX)
        hi_ctr_reg <= hi_ctr_reg + CNT_ONE;

      if (hold_hi) hi_hold_reg <= hi_ctr_reg;

      if (publish) begin
        period_cnt <= per_ctr_reg;
        high_cnt   <= hi_hold_reg;
      end

      if (ovf_set) overflow <= 1'b1;

      if (stuck_set) begin
        stuck       <= 1'b1;
        stuck_level <= sync_reg[1];
      end else if (stuck_clr) begin
        stuck <= 1'b0;
      end
    end
  end

endmodule
